// File: rtl/welford_update_if.sv
// Handshake and state bus for the Welford update engine.
// slave: the engine side; master: the producer/consumer side.
interface welford_update_if #(
  parameter int SCALING         = 32,
  parameter int DATAIN_WIDTH    = 11,
  parameter int RES_SHORT_WIDTH = 24,
  parameter int RES_LONG_WIDTH  = 40,
  parameter int DELTA_SCALING   = 18 - DATAIN_WIDTH - 1,
  parameter int M2_WIDTH        = RES_LONG_WIDTH + 2 * DELTA_SCALING + 1
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATAIN_WIDTH-1:0]           in_sample;
  logic                              in_syn;
  logic [RES_SHORT_WIDTH-1:0]        in_syn_count;
  logic [RES_SHORT_WIDTH-1:0]        in_pkt_count;
  logic [DATAIN_WIDTH+SCALING-1:0]   in_mean;
  logic [M2_WIDTH-1:0]               in_m2;
  logic                              out_valid;
  logic                              out_ready;
  logic [RES_SHORT_WIDTH-1:0]        out_syn_count;
  logic [RES_SHORT_WIDTH-1:0]        out_pkt_count;
  logic [DATAIN_WIDTH+SCALING-1:0]   out_mean;
  logic [M2_WIDTH-1:0]               out_m2;

  modport slave (
    input  in_valid, in_sample, in_syn, in_syn_count, in_pkt_count, in_mean, in_m2, out_ready,
    output in_ready, out_valid, out_syn_count, out_pkt_count, out_mean, out_m2
  );
  modport master (
    output in_valid, in_sample, in_syn, in_syn_count, in_pkt_count, in_mean, in_m2, out_ready,
    input  in_ready, out_valid, out_syn_count, out_pkt_count, out_mean, out_m2
  );
endinterface

// File: rtl/welford_update.sv
// Multicycle Welford update: counts, mean (restoring divide) and M2 for one
// flow sample. IDLE -> CALC -> [DIV x Q] -> UPD -> MUL -> OUT.
module welford_update #(
  parameter int SCALING         = 32,
  parameter int DATAIN_WIDTH    = 11,
  parameter int RES_SHORT_WIDTH = 24,
  parameter int RES_LONG_WIDTH  = 40,
  parameter int DELTA_SCALING   = 18 - DATAIN_WIDTH - 1,
  parameter int M2_WIDTH        = RES_LONG_WIDTH + 2 * DELTA_SCALING + 1
) (
  input logic              axis_aclk,
  input logic              axis_resetn,
  welford_update_if.slave  bus
);
  localparam int MW  = DATAIN_WIDTH + SCALING;   // mean width
  localparam int DW  = MW + 1;                   // signed delta width
  localparam int Q   = MW;                       // quotient bits / divide cycles
  localparam int SH  = SCALING - DELTA_SCALING;  // fraction bits dropped before multiply
  localparam int OPW = DW - SH;                  // multiplier operand width
  localparam int PW  = 2 * OPW;
  localparam int RS  = RES_SHORT_WIDTH;
  localparam int CW  = $clog2(Q + 1);
  localparam logic [M2_WIDTH-1:0] M2_MAX = {1'b0, {(M2_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, CALC, DIV, UPD, MUL, OUT} state_t;
  state_t state_q, state_d;

  logic [DATAIN_WIDTH-1:0]    x_q;
  logic                       syn_q;
  logic [RS-1:0]              syn_cnt_q;
  logic [RS-1:0]              pkt_q;      // raw count until CALC, then n
  logic [MW-1:0]              mean_q;
  logic [M2_WIDTH-1:0]        m2_q;
  logic signed [DW-1:0]       delta_q;
  logic signed [DW-1:0]       delta2_q;
  logic [MW-1:0]              div_q;      // dividend shifting out, quotient shifting in
  logic [RS-1:0]              rem_q;
  logic [CW-1:0]              cnt_q;

  logic [MW-1:0]              x_fix;
  logic [RS-1:0]              n_sat, syn_next;
  logic signed [DW-1:0]       delta_c;
  logic [MW-1:0]              delta_mag;
  logic [RS:0]                rem_sh, rem_diff;
  logic                       q_bit;
  logic [MW-1:0]              mean_new;
  logic signed [OPW-1:0]      a_op, b_op;
  logic signed [PW-1:0]       prod;
  logic [M2_WIDTH:0]          m2_sum;
  logic [M2_WIDTH-1:0]        m2_new;

  // Datapath arithmetic shared by the per-state register updates
  always_comb begin
    x_fix     = {x_q, {SCALING{1'b0}}};
    n_sat     = (&pkt_q) ? pkt_q : pkt_q + 1'b1;
    syn_next  = (syn_q && !(&syn_cnt_q)) ? syn_cnt_q + 1'b1 : syn_cnt_q;
    delta_c   = $signed({1'b0, x_fix}) - $signed({1'b0, mean_q});
    delta_mag = delta_c[DW-1] ? (mean_q - x_fix) : (x_fix - mean_q);
    // One restoring step: a negative trial difference means the bit is 0
    rem_sh    = {rem_q, div_q[MW-1]};
    rem_diff  = rem_sh - {1'b0, pkt_q};
    q_bit     = ~rem_diff[RS];
    // Quotient magnitude is truncated; the sign of delta picks add or subtract
    mean_new  = delta_q[DW-1] ? (mean_q - div_q) : (mean_q + div_q);
    a_op      = OPW'(delta_q >>> SH);
    b_op      = OPW'(delta2_q >>> SH);
    prod      = a_op * b_op;
    m2_sum    = {m2_q[M2_WIDTH-1], m2_q} + {{(M2_WIDTH+1-PW){prod[PW-1]}}, prod};
    if (m2_sum[M2_WIDTH])
      m2_new = '0;
    else if (m2_sum[M2_WIDTH-1])
      m2_new = M2_MAX;
    else
      m2_new = m2_sum[M2_WIDTH-1:0];
  end

  // State register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic; n==1 skips the divide since the quotient is delta itself
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    state_d = (n_sat == RS'(1)) ? UPD : DIV;
      DIV:     if (cnt_q == '0) state_d = UPD;
      UPD:     state_d = MUL;
      MUL:     state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);

  // Datapath and output registers, advanced per state
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      x_q <= '0; syn_q <= 1'b0; syn_cnt_q <= '0; pkt_q <= '0; mean_q <= '0; m2_q <= '0;
      delta_q <= '0; delta2_q <= '0; div_q <= '0; rem_q <= '0; cnt_q <= '0;
      bus.out_syn_count <= '0; bus.out_pkt_count <= '0; bus.out_mean <= '0; bus.out_m2 <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          x_q       <= bus.in_sample;
          syn_q     <= bus.in_syn;
          syn_cnt_q <= bus.in_syn_count;
          pkt_q     <= bus.in_pkt_count;
          mean_q    <= bus.in_mean;
          m2_q      <= bus.in_m2;
        end
        CALC: begin
          pkt_q             <= n_sat;
          bus.out_pkt_count <= n_sat;
          bus.out_syn_count <= syn_next;
          delta_q           <= delta_c;
          div_q             <= delta_mag;
          rem_q             <= '0;
          cnt_q             <= CW'(Q - 1);
        end
        DIV: begin
          rem_q <= q_bit ? rem_diff[RS-1:0] : rem_sh[RS-1:0];
          div_q <= {div_q[MW-2:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
        end
        UPD: begin
          mean_q       <= mean_new;
          bus.out_mean <= mean_new;
          delta2_q     <= $signed({1'b0, x_fix}) - $signed({1'b0, mean_new});
        end
        MUL: begin
          m2_q       <= m2_new;
          bus.out_m2 <= m2_new;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_welford_update.sv
// Self-checking bench for welford_update: vector table, corner sequences,
// randomized chained flows against a plain-arithmetic reference model.
module tb_welford_update;
  localparam longint MAXC    = (64'sd1 <<< 24) - 1;
  localparam longint M2MAX   = (64'sd1 <<< 52) - 1;
  localparam longint MEANMSK = (64'sd1 <<< 43) - 1;
  localparam int     BUDGET  = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  welford_update_if bus();
  welford_update dut (.axis_aclk(clk), .axis_resetn(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  typedef struct {
    longint syn_c, pkt, mean, m2, x;
    bit     syn;
    longint e_syn, e_pkt, e_mean, e_m2;
    int     e_lat;
  } vec_t;

  // Reference: Welford step in plain signed 64-bit arithmetic
  function automatic void model(input longint syn_c, pkt, mean, m2, x, input bit syn,
                                output longint o_syn, o_pkt, o_mean, o_m2, output int lat);
    longint n, d, q, mn, d2, s;
    n      = (pkt == MAXC) ? MAXC : pkt + 1;
    o_pkt  = n;
    o_syn  = (syn && syn_c != MAXC) ? syn_c + 1 : syn_c;
    d      = (x <<< 32) - mean;
    q      = d / n;
    mn     = mean + q;
    d2     = (x <<< 32) - mn;
    s      = m2 + (d >>> 26) * (d2 >>> 26);
    if (s > M2MAX) s = M2MAX;
    if (s < 0) s = 0;
    o_mean = mn;
    o_m2   = s;
    lat    = (n == 1) ? 3 : 46;
  endfunction

  function automatic vec_t mkvec(input longint syn_c, pkt, mean, m2, x, input bit syn);
    vec_t v;
    v.syn_c = syn_c; v.pkt = pkt; v.mean = mean; v.m2 = m2; v.x = x; v.syn = syn;
    model(syn_c, pkt, mean, m2, x, syn, v.e_syn, v.e_pkt, v.e_mean, v.e_m2, v.e_lat);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.in_sample    = v.x[10:0];
    bus.in_syn       = v.syn;
    bus.in_syn_count = v.syn_c[23:0];
    bus.in_pkt_count = v.pkt[23:0];
    bus.in_mean      = v.mean[42:0];
    bus.in_m2        = v.m2[52:0];
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = c; break; end
    end
  endtask

  task automatic check_out(input string tag, input vec_t v, input int lat);
    chk({tag, " latency"},   longint'(lat), longint'(v.e_lat));
    chk({tag, " syn_count"}, longint'(bus.out_syn_count), v.e_syn);
    chk({tag, " pkt_count"}, longint'(bus.out_pkt_count), v.e_pkt);
    chk({tag, " mean"},      longint'(bus.out_mean), v.e_mean);
    chk({tag, " m2"},        longint'($signed(bus.out_m2)), v.e_m2);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Called at #1 after an edge with the engine idle
  task automatic run(input string tag, input vec_t v);
    int lat;
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, " busy in_ready"}, longint'(bus.in_ready), 0);
    wait_valid(lat);
    check_out(tag, v, lat);
    handshake();
  endtask

  vec_t tbl[6];
  vec_t v, bp, st;
  int   lat, rose;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_sample = '0; bus.in_syn = 1'b0;
    bus.in_syn_count = '0; bus.in_pkt_count = '0; bus.in_mean = '0; bus.in_m2 = '0;

    // Hand-computed expectations for the named cases; the rest use the model
    tbl[0] = mkvec(0, 0, 0, 0, 100, 1);
    tbl[0].e_syn = 1; tbl[0].e_pkt = 1; tbl[0].e_mean = 64'sd100 <<< 32; tbl[0].e_m2 = 0; tbl[0].e_lat = 3;
    tbl[1] = mkvec(1, 1, 64'sd100 <<< 32, 0, 102, 0);
    tbl[1].e_syn = 1; tbl[1].e_pkt = 2; tbl[1].e_mean = 64'sd101 <<< 32; tbl[1].e_m2 = 2 <<< 12; tbl[1].e_lat = 46;
    tbl[2] = mkvec(1, 2, 64'sd101 <<< 32, 2 <<< 12, 99, 0);
    tbl[2].e_pkt = 3; tbl[2].e_mean = (64'sd101 <<< 32) - 64'sd2863311530; tbl[2].e_m2 = 19200;
    tbl[3] = mkvec(MAXC, MAXC, 64'sd50 <<< 32, 1000, 60, 1);
    tbl[3].e_syn = MAXC; tbl[3].e_pkt = MAXC; tbl[3].e_lat = 46;
    tbl[4] = mkvec(0, 1, 0, M2MAX - 5, 2047, 0);
    tbl[4].e_m2 = M2MAX; tbl[4].e_mean = 64'sd2047 <<< 31;
    tbl[5] = mkvec(0, 0, 0, -1000, 5, 0);
    tbl[5].e_m2 = 0; tbl[5].e_mean = 64'sd5 <<< 32;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", longint'(bus.in_ready), 1);
    chk("reset out_valid", longint'(bus.out_valid), 0);
    chk("reset out_pkt", longint'(bus.out_pkt_count), 0);
    chk("reset out_mean", longint'(bus.out_mean), 0);
    chk("reset out_m2", longint'(bus.out_m2), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release in_ready", longint'(bus.in_ready), 1);
    chk("release out_valid", longint'(bus.out_valid), 0);
    chk("release out_syn", longint'(bus.out_syn_count), 0);

    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a divide: nothing comes out
    drive(tbl[1]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rose = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) rose++;
    end
    chk("middiv out_valid rises", longint'(rose), 0);
    chk("middiv in_ready", longint'(bus.in_ready), 1);
    chk("middiv out_pkt cleared", longint'(bus.out_pkt_count), 0);

    // Backpressure with a new request held during the stall
    bp = tbl[1];
    drive(bp);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check_out("bp", bp, lat);
    drive(tbl[0]);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", longint'(bus.out_valid), 1);
      chk("bp hold in_ready", longint'(bus.in_ready), 0);
      chk("bp hold mean", longint'(bus.out_mean), bp.e_mean);
      chk("bp hold m2", longint'(bus.out_m2), bp.e_m2);
    end
    handshake();
    chk("bp idle in_ready", longint'(bus.in_ready), 1);
    chk("bp idle out_valid", longint'(bus.out_valid), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp accepted in_ready", longint'(bus.in_ready), 0);
    wait_valid(lat);
    check_out("bp next", tbl[0], lat);
    handshake();

    // Randomized flows, state chained through the model
    for (int f = 0; f < 3; f++) begin
      st = mkvec(0, 0, 0, 0, longint'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
      run($sformatf("flow%0d s0", f), st);
      for (int s = 1; s < 8; s++) begin
        v = mkvec(st.e_syn, st.e_pkt, st.e_mean, st.e_m2,
                  longint'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
        run($sformatf("flow%0d s%0d", f, s), v);
        st = v;
      end
    end

    // Randomized independent states
    for (int k = 0; k < 8; k++) begin
      v = mkvec(longint'($urandom_range(0, 5000)), longint'($urandom_range(0, 100000)),
                ((longint'($urandom()) <<< 32) | longint'($urandom())) & MEANMSK,
                (longint'($urandom()) <<< 13) | longint'($urandom_range(0, 8191)),
                longint'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
      run($sformatf("rand%0d", k), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/welford_update.md
# welford_update

Sequential Welford update engine that sits directly upstream of the feature-concatenation stage in the welford extern. For each accepted sample it takes one flow's stored state (SYN count, packet count, fixed-point mean, fixed-point M2) and one new sample, and produces the updated state. It uses a multicycle restoring divider, so it needs no hard divider. The updated state is written back to flow storage and feeds the concatenation stage.

## Interface

Parameters:

- SCALING, 32, fractional bits of mean
- DATAIN_WIDTH, 11, sample width (unsigned integer)
- RES_SHORT_WIDTH, 24, width of syn/pkt counters
- RES_LONG_WIDTH, 40, integer-part width of M2
- DELTA_SCALING, 18-DATAIN_WIDTH-1 (=6), fractional bits per multiplier operand; M2 carries 2*DELTA_SCALING fractional bits
- M2_WIDTH, RES_LONG_WIDTH+2*DELTA_SCALING+1, signed M2 width

Ports:

- axis_aclk  in  1  single clock; all logic on rising edge
- axis_resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  input state+sample valid
- in_ready  out  1  engine idle, can accept
- in_sample  in  DATAIN_WIDTH  new sample x
- in_syn  in  1  sample belongs to a SYN packet
- in_syn_count  in  RES_SHORT_WIDTH  stored SYN count
- in_pkt_count  in  RES_SHORT_WIDTH  stored packet count
- in_mean  in  DATAIN_WIDTH+SCALING  stored mean, unsigned, SCALING fractional bits
- in_m2  in  M2_WIDTH  stored M2, signed
- out_valid  out  1  updated state valid
- out_ready  in  1  consumer accepts
- out_syn_count, out_pkt_count, out_mean, out_m2  out  same widths as inputs  updated state

## Operation

- States: IDLE, CALC, DIV, UPD, MUL, OUT.
- IDLE: in_ready=1. When in_valid&&in_ready, all inputs are registered and the engine moves to CALC.
- CALC:
  - n = in_pkt_count+1; if in_pkt_count is all-ones, n = all-ones and pkt_count holds.
  - syn_count is incremented when in_syn=1, with the same saturation rule.
  - delta = (x<<SCALING) − mean, signed, DATAIN_WIDTH+SCALING+1 bits.
  - If n==1, go to UPD with mean_new = x<<SCALING and no divide. Otherwise go to DIV.
- DIV:
  - Restoring divide of |delta| by n, producing one quotient bit per cycle.
  - Q = DATAIN_WIDTH+SCALING iterations, counted by a down-counter.
  - Quotient is truncated toward zero, then delta's sign is reapplied.
  - Then go to UPD.
- UPD:
  - mean_new = mean + signed quotient. Range is guaranteed by Welford, so no clamp is needed.
  - delta2 = (x<<SCALING) − mean_new.
- MUL:
  - a = delta>>>(SCALING−DELTA_SCALING) and b = delta2>>>(SCALING−DELTA_SCALING), both arithmetic (floor).
  - m2_new = m2 + a*b.
  - If the sum exceeds the M2_WIDTH signed maximum, saturate to the maximum positive value.
  - A negative result is clamped to 0.
- OUT: out_valid=1 with outputs stable. Return to IDLE on out_ready. in_ready stays 0 until then.
- Reset: every state register, the counter and the datapath registers clear.
  - out_valid=0, in_ready=1 after release.
  - All out_* data = 0.
  - Reset mid-DIV discards the operation; no output is produced.

## Timing

- Accept on edge T. CALC occupies cycle T+1.
- For n>1, DIV occupies Q cycles (43 at defaults), then UPD, then MUL.
- out_valid rises after edge T+Q+3 (n>1) or edge T+3 (n==1).
- out_valid holds indefinitely while out_ready=0. Outputs do not change while out_valid=1.
- With out_ready held high, the next accept can occur one cycle after the OUT handshake (IDLE cycle).
- in_valid asserted while busy is ignored; the upstream holds its data until in_ready.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

## Test plan

- Reset release, idle: in_ready=1, out_valid=0, all outputs 0. Reset asserted mid-DIV: out_valid never rises, in_ready=1 after release.
- First packet: state all 0, x=100, in_syn=1.
  - Required: out_pkt_count=1, out_syn_count=1, out_mean=100<<32, out_m2=0.
  - out_valid after edge T+3.
- Second packet: state (syn=1, pkt=1, mean=100<<32, m2=0), x=102, in_syn=0.
  - Required: pkt=2, syn=1, mean=101<<32, m2=2<<12.
  - out_valid after edge T+46.
- Negative delta with truncation: state (pkt=2, mean=101<<32, m2=2<<12), x=99.
  - Required: pkt=3, mean=(101<<32)−floor((2<<32)/3) truncated toward zero, m2 matching a bit-exact golden model.
- Saturation:
  - in_pkt_count=in_syn_count=0xFFFFFF, in_syn=1: both counts stay 0xFFFFFF and n=0xFFFFFF is used.
  - in_m2 near maximum positive with a large product: out_m2 = maximum positive.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready=0.
  - A new in_valid is not accepted until the cycle after the handshake.
